// File: rtl/dmem_arbiter_if.sv
// Bundle of requester and memory-side signals for dmem_arbiter.
// lock0/lock1 exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
`ifdef DMEM_ARB_LOCK_EN
    logic          lock0, lock1;
`endif
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_WD;
    logic          mem_WE;
    logic [DW-1:0] mem_RD;
    logic          busy;

    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_RD,
        output ack0, ack1, rdata0, rdata1, mem_A, mem_WD, mem_WE, busy
    );

    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_RD,
        input  ack0, ack1, rdata0, rdata1, mem_A, mem_WD, mem_WE, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single async-read/sync-write memory.
// Optional bus locking for atomic read-modify-write is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last_gnt;
    logic          gnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          cand0, cand1;
    logic          grant;
    logic          win;
    logic          mem_we;
    logic          ack0, ack1;
    logic          busy;

`ifdef DMEM_ARB_LOCK_EN
    logic          lock_q;
    logic          lock_owner;
`endif

    // Candidate filtering and next-state/output decode; outputs depend only on registered state.
    always_comb begin
        cand0     = bus.req0;
        cand1     = bus.req1;
`ifdef DMEM_ARB_LOCK_EN
        if (lock_q) begin
            cand0 = bus.req0 & ~lock_owner;
            cand1 = bus.req1 & lock_owner;
        end
`endif
        grant     = cand0 | cand1;
        win       = (cand0 & cand1) ? ~last_gnt : cand1;

        state_nxt = state;
        mem_we    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = 1'b0;

        case (state)
            IDLE: begin
                if (grant) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_we    = we_q;
                busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                ack0      = ~gnt_q;
                ack1      = gnt_q;
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt   <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_owner <= 1'b0;
`endif
        end else begin
            if (state == IDLE && grant) begin
                gnt_q    <= win;
                last_gnt <= win;
                we_q     <= win ? bus.we1    : bus.we0;
                addr_q   <= win ? bus.addr1  : bus.addr0;
                wdata_q  <= win ? bus.wdata1 : bus.wdata0;
            end
            // Read data is captured at the same edge the memory would commit a write.
            if (state == ACCESS && !we_q) begin
                if (gnt_q) rdata1_q <= bus.mem_RD;
                else       rdata0_q <= bus.mem_RD;
            end
`ifdef DMEM_ARB_LOCK_EN
            if (state == RESP) begin
                lock_q     <= gnt_q ? bus.lock1 : bus.lock0;
                lock_owner <= gnt_q;
            end
`endif
        end
    end

    assign bus.mem_A  = addr_q;
    assign bus.mem_WD = wdata_q;
    assign bus.mem_WE = mem_we;
    assign bus.ack0   = ack0;
    assign bus.ack1   = ack1;
    assign bus.busy   = busy;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule
